// File: rtl/cpu_defs.sv
// Shared definitions for the CPU front end: fetch-state encodings, next-PC
// selector codes and the reset/bubble constants.
package cpu_defs;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INS          = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  typedef enum logic {
    FS_REQ  = 1'b0,
    FS_HOLD = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    NPC_KEEP = 2'd0,
    NPC_SEQ  = 2'd1,
    NPC_LIVE = 2'd2,
    NPC_PEND = 2'd3
  } npc_sel_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: hold, sequential +4 (wraps modulo 2^32),
// live redirect target, or the redirect captured while an access was pending.
module fetch_next_pc
  import cpu_defs::*;
(
  input  logic [1:0]  sel_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] pend_pc_i,
  output logic [31:0] npc_o,
  output logic [31:0] redirect_aligned_o
);

  assign redirect_aligned_o = word_align(redirect_pc_i);

  always_comb begin
    npc_o = pc_i;
    case (sel_i)
      NPC_SEQ:  npc_o = pc_i + 32'd4;
      NPC_LIVE: npc_o = redirect_aligned_o;
      NPC_PEND: npc_o = pend_pc_i;
      default:  npc_o = pc_i;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, issues instruction-memory requests and feeds one
// instruction or a bubble per cycle into IF/ID, honouring stalls and redirects.
module instruction_fetch_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        in_stall,
  input  logic        in_redirect,
  input  logic [31:0] in_redirect_pc,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] ins_o,
  output logic [31:0] pc_o,
  output logic        is_stalling
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_ins_q, buf_ins_d;
  logic         redir_pend_q, redir_pend_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic [31:0]  ins_q, ins_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         stalling_q, stalling_d;

  npc_sel_e     npc_sel;
  logic [31:0]  redirect_aligned;

  fetch_next_pc u_next_pc (
    .sel_i              (npc_sel),
    .pc_i               (pc_q),
    .redirect_pc_i      (in_redirect_pc),
    .pend_pc_i          (redir_pc_q),
    .npc_o              (pc_d),
    .redirect_aligned_o (redirect_aligned)
  );

  always_comb begin
    state_d      = state_q;
    npc_sel      = NPC_KEEP;
    buf_ins_d    = buf_ins_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    ins_d        = ins_q;
    pc_out_d     = pc_out_q;
    stalling_d   = stalling_q;

    case (state_q)
      FS_REQ: begin
        if (imem_ready && (in_redirect || redir_pend_q)) begin
          // Word belongs to the wrong path; a live redirect beats the pending one.
          npc_sel      = in_redirect ? NPC_LIVE : NPC_PEND;
          redir_pend_d = 1'b0;
          if (!in_stall) begin
            ins_d      = NOP_INS;
            stalling_d = 1'b1;
          end
        end else if (imem_ready) begin
          if (!in_stall) begin
            ins_d      = imem_rdata;
            pc_out_d   = pc_q;
            stalling_d = 1'b0;
            npc_sel    = NPC_SEQ;
          end else begin
            buf_ins_d = imem_rdata;
            state_d   = FS_HOLD;
          end
        end else begin
          // PC must not move while the access is outstanding; park the target.
          if (in_redirect) begin
            redir_pend_d = 1'b1;
            redir_pc_d   = redirect_aligned;
          end
          if (!in_stall) begin
            ins_d      = NOP_INS;
            stalling_d = 1'b1;
          end
        end
      end

      FS_HOLD: begin
        if (in_redirect) begin
          npc_sel = NPC_LIVE;
          state_d = FS_REQ;
          if (!in_stall) begin
            ins_d      = NOP_INS;
            stalling_d = 1'b1;
          end
        end else if (!in_stall) begin
          ins_d      = buf_ins_q;
          pc_out_d   = pc_q;
          stalling_d = 1'b0;
          npc_sel    = NPC_SEQ;
          state_d    = FS_REQ;
        end
      end

      default: state_d = FS_REQ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= FS_REQ;
      pc_q         <= word_align(RESET_PC);
      buf_ins_q    <= 32'h0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'h0;
      ins_q        <= NOP_INS;
      pc_out_q     <= word_align(RESET_PC);
      stalling_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_ins_q    <= buf_ins_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      ins_q        <= ins_d;
      pc_out_q     <= pc_out_d;
      stalling_q   <= stalling_d;
    end
  end

  assign imem_req    = (state_q == FS_REQ) && !rst;
  assign imem_addr   = pc_q;
  assign ins_o       = ins_q;
  assign pc_o        = pc_out_q;
  assign is_stalling = stalling_q;

endmodule
